// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 7-segment display blocks: segment width,
// common glyph patterns (active-high, bit order gfedcba) and a helper
// that extracts one digit's pattern from a packed multi-digit vector.
package seg_disp_pkg;

    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h00;

    localparam seg_t GLYPH_0    = 7'h3F;
    localparam seg_t GLYPH_1    = 7'h06;
    localparam seg_t GLYPH_2    = 7'h5B;
    localparam seg_t GLYPH_3    = 7'h4F;
    localparam seg_t GLYPH_4    = 7'h66;
    localparam seg_t GLYPH_5    = 7'h6D;
    localparam seg_t GLYPH_6    = 7'h7D;
    localparam seg_t GLYPH_7    = 7'h07;
    localparam seg_t GLYPH_8    = 7'h7F;
    localparam seg_t GLYPH_9    = 7'h6F;
    localparam seg_t GLYPH_H    = 7'h76;
    localparam seg_t GLYPH_O    = 7'h3F;
    localparam seg_t GLYPH_L    = 7'h38;
    localparam seg_t GLYPH_A    = 7'h77;
    localparam seg_t GLYPH_DASH = 7'h40;

    // Callers zero-extend their digit vector to MAX_DIGITS digits so one
    // function serves every bank width; k must be below MAX_DIGITS.
    function automatic seg_t digit_slice(input logic [SEG_W*MAX_DIGITS-1:0] vec,
                                         input int k);
        return vec[SEG_W*k +: SEG_W];
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Clock-enable divider: counts 0..DIV-1 in the clk domain and raises a
// one-cycle tick on the terminal count. hold parks the count at zero.
module clk_en_divider #(
    parameter int DIV = 1350,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    // Wrapping counter, parked at zero while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hold || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !hold && (count == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver. Scans N_DIGITS digits
// leftmost first, one CLK_DIV-cycle slot each with DEAD_CYC dark cycles at
// the slot start. Display data is double-buffered and only swapped at the
// frame boundary, so a frame never mixes old and new digits.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 1350,
    parameter int DEAD_CYC     = 2,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [SEG_W*N_DIGITS-1:0] digits_in,
    input  logic                      load,
    input  logic [N_DIGITS-1:0]       blank_mask,
    input  logic [N_DIGITS-1:0]       blink_mask,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [SEG_W-1:0]          seg_out,
    output logic [N_DIGITS-1:0]       an_out,
    output logic                      frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0] DEAD_END   = DIV_W'(DEAD_CYC);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic                            tick;
    logic [DIV_W-1:0]                div_cnt;
    logic [IDX_W-1:0]                idx;
    logic [BRIGHT_W-1:0]             pwm_cnt;
    logic [SEG_W*N_DIGITS-1:0]       pending;
    logic [SEG_W*N_DIGITS-1:0]       active;
    logic [BLK_W-1:0]                blink_cnt;
    logic                            blink_phase;
    logic                            boundary;
    logic                            pwm_on;
    logic                            lit;
    logic [SEG_W*MAX_DIGITS-1:0]     active_ext;
    logic [N_DIGITS-1:0]             an_next;
    logic [SEG_W-1:0]                seg_next;

    clk_en_divider #(
        .DIV (CLK_DIV)
    ) u_slot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (!enable),
        .tick  (tick),
        .count (div_cnt)
    );

    assign boundary = enable && tick && (idx == '0);

    // Digit index walks leftmost to rightmost; parked on the leftmost while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= IDX_LAST;
        end else if (!enable) begin
            idx <= IDX_LAST;
        end else if (tick) begin
            idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
        end
    end

    // Double buffer: loads land in pending, active swaps only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (load) begin
                pending <= digits_in;
            end
            if (boundary) begin
                active <= load ? digits_in : pending;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES frame boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!enable) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Free-running PWM phase counter for brightness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Decide whether the current digit is lit and what the pins should show next
    always_comb begin
        active_ext                      = '0;
        active_ext[SEG_W*N_DIGITS-1:0]  = active;
        pwm_on   = (&brightness) || (pwm_cnt < brightness);
        lit      = enable && (div_cnt >= DEAD_END) && pwm_on &&
                   !blank_mask[idx] && !(blink_mask[idx] && blink_phase);
        an_next  = '1;
        seg_next = SEG_BLANK;
        if (lit) begin
            an_next[idx] = 1'b0;
            seg_next     = digit_slice(active_ext, int'(idx));
        end
    end

    // Registered pin drive and frame strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_out     <= '1;
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an_out     <= an_next;
            seg_out    <= seg_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised self-checking bench for seg_scan_mux. A reference model
// derives the expected pins from elapsed scan time (slot = t / CLK_DIV,
// frame = t / frame length) and a per-digit frame buffer.
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int BW    = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [27:0]   digits_in;
    logic          load;
    logic [3:0]    blank_mask;
    logic [3:0]    blink_mask;
    logic [3:0]    brightness;
    logic [6:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_done;

    int tests_run;
    int tests_failed;

    seg_scan_mux #(
        .N_DIGITS     (N),
        .CLK_DIV      (DIV),
        .DEAD_CYC     (DEAD),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digits_in  (digits_in),
        .load       (load),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_t;
    int         m_c;
    logic [6:0] m_pend [N];
    logic [6:0] m_act  [N];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fd;

    function automatic logic [6:0] din_digit(input logic [27:0] v, input int k);
        return v[7*k +: 7];
    endfunction

    function automatic int model_digit(input int t);
        return N - 1 - ((t / DIV) % N);
    endfunction

    function automatic bit model_lit(input int t, input int c, input logic [3:0] bright,
                                     input logic [3:0] blank, input logic [3:0] blink);
        int  d;
        bit  phase;
        bit  pwm_on;
        d      = model_digit(t);
        phase  = (((t / FRAME) / BF) % 2) == 1;
        pwm_on = (bright == 4'hF) || ((c % 16) < int'(bright));
        return ((t % DIV) >= DEAD) && pwm_on && !blank[d] && !(blink[d] && phase);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_t     <= 0;
            m_c     <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h00;
            exp_fd  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                m_pend[k] <= 7'h00;
                m_act[k]  <= 7'h00;
            end
        end else begin
            m_c <= m_c + 1;
            if (enable) begin
                if (model_lit(m_t, m_c, brightness, blank_mask, blink_mask)) begin
                    exp_an  <= 4'(~(4'b0001 << model_digit(m_t)));
                    exp_seg <= m_act[model_digit(m_t)];
                end else begin
                    exp_an  <= 4'hF;
                    exp_seg <= 7'h00;
                end
                exp_fd <= (m_t % FRAME) == FRAME - 1;
                if ((m_t % FRAME) == FRAME - 1) begin
                    for (int k = 0; k < N; k++) begin
                        m_act[k] <= load ? din_digit(digits_in, k) : m_pend[k];
                    end
                end
                m_t <= m_t + 1;
            end else begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h00;
                exp_fd  <= 1'b0;
                m_t     <= 0;
            end
            if (load) begin
                for (int k = 0; k < N; k++) begin
                    m_pend[k] <= din_digit(digits_in, k);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        digits_in  = '0;
        blank_mask = '0;
        blink_mask = '0;
        brightness = 4'hF;
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (an_out !== 4'hF || seg_out !== 7'h00 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: an=%b seg=%h fd=%b, want an=1111 seg=00 fd=0",
                     an_out, seg_out, frame_done);
        end
        @(negedge clk);
        tests_run++;
        if (an_out !== 4'hF || seg_out !== 7'h00 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: an=%b seg=%h fd=%b, want an=1111 seg=00 fd=0",
                     an_out, seg_out, frame_done);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_hola();
        int       fd_count;
        int       lit_count;
        logic [6:0] want;
        bit       known;
        enable    = 1'b1;
        load      = 1'b1;
        digits_in = {7'h76, 7'h3F, 7'h38, 7'h77};
        fd_count  = 0;
        lit_count = 0;
        for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL scan cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            if (frame_done === 1'b1) fd_count++;
            if (cyc >= FRAME && cyc < 2 * FRAME) begin
                known = 1'b1;
                case (an_out)
                    4'b0111: want = 7'h76;
                    4'b1011: want = 7'h3F;
                    4'b1101: want = 7'h38;
                    4'b1110: want = 7'h77;
                    4'b1111: want = 7'h00;
                    default: begin want = 7'h00; known = 1'b0; end
                endcase
                if (an_out !== 4'b1111) lit_count++;
                tests_run++;
                if (!known || seg_out !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL hola_glyph cyc%0d: an=%b seg=%h, want seg=%h", cyc, an_out, seg_out, want);
                end
            end
        end
        tests_run++;
        if (fd_count != 3) begin
            tests_failed++;
            $display("[TB] FAIL frame_done_count: got %0d, want 3", fd_count);
        end
        tests_run++;
        if (lit_count != 24) begin
            tests_failed++;
            $display("[TB] FAIL lit_cycles_per_frame: got %0d, want 24", lit_count);
        end
    endtask

    task automatic test_load_timing();
        for (int cyc = 0; cyc < 5 * FRAME; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL load cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            load = 1'b0;
            if (cyc < 2 * FRAME && (m_t % FRAME) == 12) begin
                load      = 1'b1;
                digits_in = 28'($urandom);
            end else if (cyc >= 2 * FRAME && cyc < 4 * FRAME && (m_t % FRAME) == FRAME - 1) begin
                load      = 1'b1;
                digits_in = 28'($urandom);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_masks();
        for (int cyc = 0; cyc < 10 * FRAME; cyc++) begin
            if (cyc == 0)         blank_mask = 4'b0010;
            if (cyc == 2 * FRAME) begin blank_mask = 4'b0000; blink_mask = 4'b0001; end
            if (cyc >= 7 * FRAME && (cyc % 16) == 0) begin
                blank_mask = 4'($urandom);
                blink_mask = 4'($urandom);
            end
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL mask cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        blank_mask = '0;
        blink_mask = '0;
    endtask

    task automatic test_brightness();
        for (int cyc = 0; cyc < 6 * FRAME; cyc++) begin
            if (cyc == 0)         brightness = 4'h4;
            if (cyc == 2 * FRAME) brightness = 4'h0;
            if (cyc >= 4 * FRAME && (cyc % 16) == 0) brightness = 4'($urandom);
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL bright cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            if (cyc > 2 * FRAME && cyc < 4 * FRAME) begin
                tests_run++;
                if (an_out !== 4'hF) begin
                    tests_failed++;
                    $display("[TB] FAIL bright_zero_dark cyc%0d: an=%b, want 1111", cyc, an_out);
                end
            end
        end
        brightness = 4'hF;
    endtask

    task automatic test_enable();
        bit dropped;
        int drop_cyc;
        dropped  = 1'b0;
        drop_cyc = 0;
        for (int cyc = 0; cyc < 6 * FRAME; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL enable cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            if (!dropped && cyc >= 40 && (m_t % DIV) == 4) begin
                enable   = 1'b0;
                dropped  = 1'b1;
                drop_cyc = cyc;
            end else if (dropped && cyc == drop_cyc + 40) begin
                enable = 1'b1;
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL pre_reset cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (an_out !== 4'hF || seg_out !== 7'h00 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_async: an=%b seg=%h fd=%b, want an=1111 seg=00 fd=0",
                     an_out, seg_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3 * FRAME; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL post_reset cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            if (cyc < FRAME) begin
                tests_run++;
                if (seg_out !== 7'h00) begin
                    tests_failed++;
                    $display("[TB] FAIL post_reset_blank cyc%0d: seg=%h, want 00", cyc, seg_out);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (an_out !== exp_an || seg_out !== exp_seg || frame_done !== exp_fd) begin
                tests_failed++;
                $display("[TB] FAIL random cyc%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                         cyc, an_out, seg_out, frame_done, exp_an, exp_seg, exp_fd);
            end
            load      = ($urandom_range(0, 9) == 0);
            digits_in = 28'($urandom);
            if ($urandom_range(0, 29) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 149) == 0) enable = !enable;
        end
        load = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_scan_hola();
        test_load_timing();
        test_masks();
        test_brightness();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
